// File: rtl/avalon_mm_slave.sv
// Avalon-MM slave with three R/W registers and a read-pop transmit FIFO.
// Fixed-latency handshake: WAITREQUEST drops for one ACCESS cycle WAIT_CYCLES+1 cycles after BEGINTRANSFER.
module avalon_mm_slave #(
  parameter int WAIT_CYCLES = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [31:0]                   ADDRESS,
  input  logic                          BEGINTRANSFER,
  input  logic                          READ,
  input  logic                          WRITE,
  input  logic [31:0]                   WRITEDATA,
  input  logic                          LOCK,
  output logic [31:0]                   READDATA,
  output logic                          WAITREQUEST,
  output logic [31:0]                   REG0_OUT,
  output logic [31:0]                   REG1_OUT,
  output logic [31:0]                   REG2_OUT,
  output logic [2:0]                    WR_STROBE,
  input  logic [31:0]                   FIFO_WDATA,
  input  logic                          FIFO_PUSH,
  output logic                          FIFO_FULL,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          OVERFLOW
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] WLAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [2:0][31:0]  regs_q;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q;
  logic              ovf_q;

  logic       in_access, hit, do_rd, do_wr, empty, full, pop, push;
  logic [1:0] idx;
  logic       unused;

  assign unused = ^{LOCK, addr_q[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: if (BEGINTRANSFER) begin
        addr_d  = ADDRESS;
        wdata_d = WRITEDATA;
        rd_d    = READ;
        wr_d    = WRITE;
        cnt_d   = 4'd0;
        state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == WLAST) state_d = S_ACCESS;
        else                cnt_d   = cnt_q + 4'd1;
      end
      S_ACCESS: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Both or neither of READ/WRITE is a no-op, as are accesses outside 0x0..0xC.
  assign in_access = (state_q == S_ACCESS);
  assign hit       = (addr_q[31:4] == 28'd0);
  assign idx       = addr_q[3:2];
  assign do_rd     = in_access & rd_q & ~wr_q & hit;
  assign do_wr     = in_access & wr_q & ~rd_q & hit & (idx != 2'd3);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = do_rd & (idx == 2'd3) & ~empty;
  // A pop in the same cycle frees a slot, so a push against a full FIFO still lands.
  assign push      = FIFO_PUSH & (~full | pop);

  always_comb begin
    READDATA = 32'd0;
    if (do_rd) begin
      case (idx)
        2'd0: READDATA = regs_q[0];
        2'd1: READDATA = regs_q[1];
        2'd2: READDATA = regs_q[2];
        default: if (!empty) READDATA = mem_q[rptr_q];
      endcase
    end
  end

  assign WAITREQUEST = ~in_access;
  assign WR_STROBE   = do_wr ? (3'b001 << idx) : 3'b000;
  assign REG0_OUT    = regs_q[0];
  assign REG1_OUT    = regs_q[1];
  assign REG2_OUT    = regs_q[2];
  assign FIFO_FULL   = full;
  assign FIFO_COUNT  = count_q;
  assign OVERFLOW    = ovf_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      regs_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      for (int i = 0; i < 3; i++)
        if (WR_STROBE[i]) regs_q[i] <= wdata_q;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (FIFO_PUSH && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= FIFO_WDATA;
  end
endmodule
